// File: rtl/mux_nx1_rr_reg.sv
// mux_nx1_rr_reg: registered N:1 channel mux with valid/ready, direct or round-robin select
module mux_nx1_rr_reg #(
    parameter int P  = 32,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MODE,
    input  logic [SW-1:0] MS,
    input  logic [N*P-1:0] D_in,
    input  logic [N-1:0]  D_valid,
    output logic [N-1:0]  D_ready,
    output logic [P-1:0]  D_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] GRANT
);
    logic [SW-1:0] ptr;
    logic [SW-1:0] sel;
    logic          cand;
    logic          accept;
    logic          xfer;
    logic [P-1:0]  sel_data;

    assign accept = !out_valid || out_ready;
    assign xfer   = accept && cand && rst;

    // pick the candidate: fixed index in direct mode, first valid at or after ptr (wrapping) in round-robin
    always_comb begin
        cand = 1'b0;
        sel  = '0;
        if (!MODE) begin
            for (int i = 0; i < N; i++)
                if (MS == SW'(i) && D_valid[i]) begin
                    cand = 1'b1;
                    sel  = MS;
                end
        end else begin
            for (int i = 0; i < N; i++)
                if (!cand && D_valid[i] && SW'(i) >= ptr) begin
                    cand = 1'b1;
                    sel  = SW'(i);
                end
            for (int i = 0; i < N; i++)
                if (!cand && D_valid[i]) begin
                    cand = 1'b1;
                    sel  = SW'(i);
                end
        end
    end

    // one-hot ready to the selected producer and the matching data word
    always_comb begin
        D_ready  = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            D_ready[i] = xfer && (sel == SW'(i));
            if (sel == SW'(i)) sel_data = D_in[i*P +: P];
        end
    end

    // output register: load on transfer, clear valid on drain, hold on stall; ptr moves past each served channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            D_out     <= '0;
            GRANT     <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            D_out     <= sel_data;
            GRANT     <= sel;
            out_valid <= 1'b1;
            ptr       <= (sel == SW'(N-1)) ? '0 : sel + SW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// tb_mux_nx1_rr_reg: directed checks for the registered round-robin channel mux
module tb_mux_nx1_rr_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          tests = 0;
    int          fails = 0;

    // N=4 instance with a 3-bit select so out-of-range MS can be exercised
    logic        mode0 = 1'b1;
    logic [2:0]  ms0 = '0;
    logic [127:0] d_in0 = '0;
    logic [3:0]  d_valid0 = '0;
    logic [3:0]  d_ready0;
    logic [31:0] d_out0;
    logic        out_valid0;
    logic        out_ready0 = 1'b1;
    logic [2:0]  grant0;

    // N=3 instance (not a power of two)
    logic        mode1 = 1'b1;
    logic [1:0]  ms1 = '0;
    logic [95:0] d_in1 = '0;
    logic [2:0]  d_valid1 = '0;
    logic [2:0]  d_ready1;
    logic [31:0] d_out1;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [1:0]  grant1;

    mux_nx1_rr_reg #(.P(32), .N(4), .SW(3)) u0 (
        .clk(clk), .rst(rst), .MODE(mode0), .MS(ms0), .D_in(d_in0), .D_valid(d_valid0),
        .D_ready(d_ready0), .D_out(d_out0), .out_valid(out_valid0), .out_ready(out_ready0), .GRANT(grant0));

    mux_nx1_rr_reg #(.P(32), .N(3), .SW(2)) u1 (
        .clk(clk), .rst(rst), .MODE(mode1), .MS(ms1), .D_in(d_in1), .D_valid(d_valid1),
        .D_ready(d_ready1), .D_out(d_out1), .out_valid(out_valid1), .out_ready(out_ready1), .GRANT(grant1));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_in0 = {32'h4444_0003, 32'h3F80_0000, 32'h2222_0001, 32'h1111_0000};
        d_in1 = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        d_valid0 = 4'b1111;
        mode0 = 1'b1;
        step();
        step();
        tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid0); end
        tests++; if (d_out0 !== 32'h0) begin fails++; $display("FAIL reset_dout got %h want 0", d_out0); end
        tests++; if (grant0 !== 3'd0) begin fails++; $display("FAIL reset_grant got %0d want 0", grant0); end
        tests++; if (d_ready0 !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", d_ready0); end
        rst = 1'b1;
        #1;
        tests++; if (d_ready0 !== 4'b0001) begin fails++; $display("FAIL post_reset_ready got %b want 0001", d_ready0); end
        step();
        tests++; if (out_valid0 !== 1'b1 || grant0 !== 3'd0 || d_out0 !== 32'h1111_0000) begin fails++; $display("FAIL first_capture got v=%b g=%0d d=%h want v=1 g=0 d=11110000", out_valid0, grant0, d_out0); end
    endtask

    task automatic test_direct();
        mode0 = 1'b0;
        ms0 = 3'd2;
        d_valid0 = 4'b0100;
        out_ready0 = 1'b1;
        #1;
        tests++; if (d_ready0 !== 4'b0100) begin fails++; $display("FAIL direct_ready got %b want 0100", d_ready0); end
        step();
        tests++; if (d_out0 !== 32'h3F80_0000 || grant0 !== 3'd2 || out_valid0 !== 1'b1) begin fails++; $display("FAIL direct_capture got v=%b g=%0d d=%h want v=1 g=2 d=3f800000", out_valid0, grant0, d_out0); end
        ms0 = 3'd5;
        d_valid0 = 4'b1111;
        #1;
        tests++; if (d_ready0 !== 4'b0000) begin fails++; $display("FAIL direct_ms_oob_ready got %b want 0000", d_ready0); end
        step();
        tests++; if (out_valid0 !== 1'b0 || d_out0 !== 32'h3F80_0000 || grant0 !== 3'd2) begin fails++; $display("FAIL direct_ms_oob_nocapture got v=%b g=%0d d=%h want v=0 g=2 d=3f800000", out_valid0, grant0, d_out0); end
        ms0 = 3'd3;
        d_valid0 = 4'b1000;
        step();
        tests++; if (grant0 !== 3'd3 || d_out0 !== 32'h4444_0003) begin fails++; $display("FAIL direct_ch3 got g=%0d d=%h want g=3 d=44440003", grant0, d_out0); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_all [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [2:0] exp_sub [4] = '{3'd3, 3'd0, 3'd3, 3'd0};
        mode0 = 1'b1;
        d_valid0 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (grant0 !== exp_all[k] || out_valid0 !== 1'b1 || d_out0 !== d_in0[exp_all[k]*32 +: 32]) begin fails++; $display("FAIL rr_all[%0d] got g=%0d v=%b d=%h want g=%0d v=1", k, grant0, out_valid0, d_out0, exp_all[k]); end
        end
        d_valid0 = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (grant0 !== exp_sub[k] || out_valid0 !== 1'b1 || d_out0 !== d_in0[exp_sub[k]*32 +: 32]) begin fails++; $display("FAIL rr_1001[%0d] got g=%0d v=%b d=%h want g=%0d v=1", k, grant0, out_valid0, d_out0, exp_sub[k]); end
        end
    endtask

    task automatic test_backpressure();
        out_ready0 = 1'b0;
        d_valid0 = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (d_ready0 !== 4'b0000) begin fails++; $display("FAIL stall_ready[%0d] got %b want 0000", k, d_ready0); end
            step();
            tests++; if (grant0 !== 3'd0 || d_out0 !== 32'h1111_0000 || out_valid0 !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d] got g=%0d v=%b d=%h want g=0 v=1 d=11110000", k, grant0, out_valid0, d_out0); end
        end
        out_ready0 = 1'b1;
        #1;
        tests++; if (d_ready0 !== 4'b0010) begin fails++; $display("FAIL unstall_ready got %b want 0010", d_ready0); end
        step();
        tests++; if (grant0 !== 3'd1 || d_out0 !== 32'h2222_0001 || out_valid0 !== 1'b1) begin fails++; $display("FAIL unstall_load got g=%0d v=%b d=%h want g=1 v=1 d=22220001", grant0, out_valid0, d_out0); end
    endtask

    task automatic test_drain();
        d_valid0 = 4'b0000;
        out_ready0 = 1'b1;
        #1;
        tests++; if (d_ready0 !== 4'b0000) begin fails++; $display("FAIL drain_ready got %b want 0000", d_ready0); end
        step();
        tests++; if (out_valid0 !== 1'b0 || d_out0 !== 32'h2222_0001 || grant0 !== 3'd1) begin fails++; $display("FAIL drain got g=%0d v=%b d=%h want g=1 v=0 d=22220001", grant0, out_valid0, d_out0); end
    endtask

    task automatic test_non_pow2();
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        mode1 = 1'b0;
        ms1 = 2'd3;
        d_valid1 = 3'b111;
        #1;
        tests++; if (d_ready1 !== 3'b000) begin fails++; $display("FAIL n3_ms3_ready got %b want 000", d_ready1); end
        step();
        tests++; if (out_valid1 !== 1'b0) begin fails++; $display("FAIL n3_ms3_nocapture got %b want 0", out_valid1); end
        mode1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            tests++; if (grant1 !== exp_g[k] || out_valid1 !== 1'b1 || d_out1 !== d_in1[exp_g[k]*32 +: 32]) begin fails++; $display("FAIL n3_rr[%0d] got g=%0d v=%b d=%h want g=%0d v=1", k, grant1, out_valid1, d_out1, exp_g[k]); end
        end
        #2;
        rst = 1'b0;
        #1;
        tests++; if (out_valid1 !== 1'b0 || grant1 !== 2'd0 || d_out1 !== 32'h0 || d_ready1 !== 3'b000) begin fails++; $display("FAIL async_reset got g=%0d v=%b d=%h r=%b want all 0", grant1, out_valid1, d_out1, d_ready1); end
        rst = 1'b1;
        step();
        tests++; if (grant1 !== 2'd0 || out_valid1 !== 1'b1) begin fails++; $display("FAIL after_reset_ptr got g=%0d v=%b want g=0 v=1", grant1, out_valid1); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_non_pow2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
